ram_256b: RTL and testbench
===========================

Name: ram_256b

Overview:
- 256-byte, byte-addressed, big-endian data memory for the SPARC-style processor datapath.
- Performs load/store byte, halfword and word transfers selected by a 6-bit opcode.
- Uses an asynchronous-style request/complete handshake: MFA (memory function activate) in, MFC (memory function complete) out.
- Storage is an internal byte array named ram, indexed 0..255, so benches can preload or inspect it hierarchically.

Parameters:
- MFC_DELAY, 2, number of clk cycles spent in BUSY before MFC asserts (minimum 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_out  output  32  load result, zero- or sign-extended; held until the next completed load.
- MFC  output  1  memory function complete.
- MFA  input  1  memory function activate (request), level-sensitive.
- opcode  input  6  operation select.
- addr  input  8  byte address.
- data_in  input  32  store data; the low bytes are used for byte and halfword stores.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - MFC=0, data_out=32'h0, FSM to IDLE.
  - ram contents are not cleared.
- Opcodes:
  - 0x01 LDUB: load byte, zero-extend.
  - 0x09 LDSB: load byte, sign-extend.
  - 0x02 LDUH: load halfword, zero-extend.
  - 0x0A LDSH: load halfword, sign-extend.
  - 0x08 LD: load word.
  - 0x05 STB: store byte, data_in[7:0].
  - 0x06 STH: store halfword, data_in[15:0].
  - 0x04 ST: store word, data_in[31:0].
  - Any other opcode is a NOP: no write, data_out unchanged, handshake still completes.
- Byte ordering is big-endian:
  - Halfword at A: ram[A] is bits [15:8], ram[A+1] is bits [7:0].
  - Word at A: ram[A], ram[A+1], ram[A+2], ram[A+3] hold bits [31:24], [23:16], [15:8], [7:0].
- Alignment is not enforced: unaligned halfword and word accesses are legal.
- Byte addresses A+k wrap modulo 256.
- FSM states IDLE, BUSY, DONE:
  - IDLE: MFC=0. On a clk edge with MFA=1, capture opcode, addr and data_in; clear the delay counter; go to BUSY. Inputs may change after capture without effect.
  - BUSY: count cycles. After MFC_DELAY cycles, perform the operation exactly once (write ram, or register data_out for a load), set MFC=1 and go to DONE.
  - DONE: MFC=1 and data_out stable. On a clk edge with MFA=0, set MFC=0 and go to IDLE.
  - MFA held high in DONE does not retrigger. A new request requires MFA to be low for at least one edge.
- MFA dropping during BUSY does not abort the transaction. The operation completes and MFC pulses for at least one cycle, then returns to IDLE.
- Reset during BUSY aborts the transaction: no ram write occurs if the operation has not yet been performed.
- Loads return the data present before any store in the same transaction; only one operation is performed per transaction.
- data_out changes only on completion of a load, or on reset.

Test Plan:
- Sequential stores: STB 0x01@0x00, STB 0x23@0x01, STH 0x4567@0x02, ST 0x123ABCDF@0x04 -> ram[0..7] = 01 23 45 67 12 3A BC DF.
- Word and byte loads after the stores: LD@0x00 -> 0x01234567; LD@0x04 -> 0x123ABCDF; LDUB@0x00 -> 0x00000001; LDSB@0x04 -> 0x00000012; LDSB@0x06 -> 0xFFFFFFBC; LDUB@0x06 -> 0x000000BC.
- Halfword loads, including unaligned: LDUH@0x03 -> 0x00006712; LDUH@0x06 -> 0x0000BCDF; LDSH@0x02 -> 0x00004567; LDSH@0x06 -> 0xFFFFBCDF.
- Wrap-around and NOP: ST 0xA1B2C3D4@0xFE -> ram[FE]=A1, ram[FF]=B2, ram[00]=C3, ram[01]=D4; LD@0xFE returns 0xA1B2C3D4; opcode 0x3F -> no ram change, data_out unchanged, MFC still pulses.
- Handshake timing: MFA rises -> MFC=1 exactly MFC_DELAY+1 edges later; MFC stays high while MFA is held; MFC clears one edge after MFA falls; a held MFA never causes a second write.
- Reset mid-BUSY during a STB to 0x10 -> ram[0x10] unchanged, MFC=0, data_out=0; the next transaction works normally.

Source files
------------

// File: rtl/ram_256b.sv
// 256-byte big-endian data memory with an MFA/MFC request/complete handshake.
// Supports byte/halfword/word loads (zero- or sign-extended) and stores, unaligned, wrapping.
module ram_256b #(
    parameter int unsigned MFC_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] data_out,
    output logic        MFC,
    input  logic        MFA,
    input  logic [5:0]  opcode,
    input  logic [7:0]  addr,
    input  logic [31:0] data_in
);

    localparam int unsigned CntW = (MFC_DELAY > 1) ? $clog2(MFC_DELAY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MFC_DELAY - 1);

    localparam logic [5:0] OpLdub = 6'h01;
    localparam logic [5:0] OpLdsb = 6'h09;
    localparam logic [5:0] OpLduh = 6'h02;
    localparam logic [5:0] OpLdsh = 6'h0A;
    localparam logic [5:0] OpLd   = 6'h08;
    localparam logic [5:0] OpStb  = 6'h05;
    localparam logic [5:0] OpSth  = 6'h06;
    localparam logic [5:0] OpSt   = 6'h04;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    logic [7:0] ram [0:255];

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      op_q, op_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_out_q, data_out_d;
    logic            mfc_q, mfc_d;

    logic [7:0]  a1, a2, a3;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [2:0]  wr_bytes;

    assign a1 = addr_q + 8'd1;
    assign a2 = addr_q + 8'd2;
    assign a3 = addr_q + 8'd3;
    assign rd_word = {ram[addr_q], ram[a1], ram[a2], ram[a3]};

    assign data_out = data_out_q;
    assign MFC      = mfc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        mfc_d      = mfc_q;
        wr_bytes   = 3'd0;
        wr_word    = 32'h0;
        unique case (state_q)
            StIdle: begin
                mfc_d = 1'b0;
                if (MFA) begin
                    op_d    = opcode;
                    addr_d  = addr;
                    wdata_d = data_in;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == CntLast) begin
                    mfc_d   = 1'b1;
                    state_d = StDone;
                    // Store data is left-justified so byte k always lands at addr+k.
                    case (op_q)
                        OpLdub: data_out_d = {24'h0, rd_word[31:24]};
                        OpLdsb: data_out_d = {{24{rd_word[31]}}, rd_word[31:24]};
                        OpLduh: data_out_d = {16'h0, rd_word[31:16]};
                        OpLdsh: data_out_d = {{16{rd_word[31]}}, rd_word[31:16]};
                        OpLd:   data_out_d = rd_word;
                        OpStb: begin
                            wr_bytes = 3'd1;
                            wr_word  = {wdata_q[7:0], 24'h0};
                        end
                        OpSth: begin
                            wr_bytes = 3'd2;
                            wr_word  = {wdata_q[15:0], 16'h0};
                        end
                        OpSt: begin
                            wr_bytes = 3'd4;
                            wr_word  = wdata_q;
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (!MFA) begin
                    mfc_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= 6'h0;
            addr_q     <= 8'h0;
            wdata_q    <= 32'h0;
            data_out_q <= 32'h0;
            mfc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            mfc_q      <= mfc_d;
        end
    end

    // Storage is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_bytes > 3'd0) ram[addr_q] <= wr_word[31:24];
            if (wr_bytes > 3'd1) ram[a1]     <= wr_word[23:16];
            if (wr_bytes > 3'd3) begin
                ram[a2] <= wr_word[15:8];
                ram[a3] <= wr_word[7:0];
            end
        end
    end

endmodule

// File: tb/tb_ram_256b.sv
// Self-checking bench for ram_256b: directed vector table, handshake/reset corner
// sequences, and random transactions against a byte-array reference model.
module tb_ram_256b;

    localparam int unsigned MFC_DELAY = 2;

    logic        clk;
    logic        reset;
    logic [31:0] data_out;
    logic        MFC;
    logic        MFA;
    logic [5:0]  opcode;
    logic [7:0]  addr;
    logic [31:0] data_in;

    ram_256b #(.MFC_DELAY(MFC_DELAY)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_out (data_out),
        .MFC      (MFC),
        .MFA      (MFA),
        .opcode   (opcode),
        .addr     (addr),
        .data_in  (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [256];
    logic [31:0] mdout;

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned mbyte(input logic [7:0] a, input int k);
        return int'(mem[(int'(a) + k) % 256]);
    endfunction

    task automatic model_apply(input logic [5:0] op, input logic [7:0] a, input logic [31:0] d);
        int v;
        case (op)
            6'h01: mdout = 32'(mbyte(a, 0));
            6'h09: begin
                v = int'(mbyte(a, 0));
                if (v >= 128) v -= 256;
                mdout = 32'(v);
            end
            6'h02: mdout = 32'(mbyte(a, 0) * 256 + mbyte(a, 1));
            6'h0A: begin
                v = int'(mbyte(a, 0) * 256 + mbyte(a, 1));
                if (v >= 32768) v -= 65536;
                mdout = 32'(v);
            end
            6'h08: mdout = 32'(mbyte(a, 0) * 16777216 + mbyte(a, 1) * 65536
                               + mbyte(a, 2) * 256 + mbyte(a, 3));
            6'h05: mem[a] = 8'(d % 256);
            6'h06: begin
                mem[a]        = 8'((d / 256) % 256);
                mem[8'(a + 1)] = 8'(d % 256);
            end
            6'h04: for (int k = 0; k < 4; k++)
                mem[8'(int'(a) + k)] = 8'((d >> (8 * (3 - k))) % 256);
            default: ;
        endcase
    endtask

    // Full handshake: raise MFA, time MFC, drop MFA, confirm MFC clears.
    task automatic do_txn(input logic [5:0] op, input logic [7:0] a, input logic [31:0] d);
        int edges;
        bit got;
        opcode  = op;
        addr    = a;
        data_in = d;
        MFA     = 1'b1;
        edges   = 0;
        got     = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (MFC) got = 1'b1;
        end
        check("mfc_latency", 32'(edges), 32'(MFC_DELAY + 1));
        opcode  = 6'($urandom);
        addr    = 8'($urandom);
        data_in = $urandom;
        MFA     = 1'b0;
        @(posedge clk);
        #1;
        check("mfc_clear", {31'h0, MFC}, 32'h0);
        model_apply(op, a, d);
    endtask

    vec_t vecs[$];
    logic [5:0] rops [10];

    initial begin
        int edges;
        bit got;

        reset = 1'b1; MFA = 1'b0; opcode = 6'h0; addr = 8'h0; data_in = 32'h0;
        mdout = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mfc", {31'h0, MFC}, 32'h0);
        check("reset_dout", data_out, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) do_txn(6'h04, 8'(i * 4), 32'h0);

        vecs = '{
            '{6'h05, 8'h00, 32'hFFFF_FF01, 32'h0000_0000},
            '{6'h05, 8'h01, 32'h0000_0023, 32'h0000_0000},
            '{6'h06, 8'h02, 32'hABCD_4567, 32'h0000_0000},
            '{6'h04, 8'h04, 32'h123A_BCDF, 32'h0000_0000},
            '{6'h08, 8'h00, 32'h0,         32'h0123_4567},
            '{6'h08, 8'h04, 32'h0,         32'h123A_BCDF},
            '{6'h01, 8'h00, 32'h0,         32'h0000_0001},
            '{6'h09, 8'h04, 32'h0,         32'h0000_0012},
            '{6'h09, 8'h06, 32'h0,         32'hFFFF_FFBC},
            '{6'h01, 8'h06, 32'h0,         32'h0000_00BC},
            '{6'h02, 8'h03, 32'h0,         32'h0000_6712},
            '{6'h02, 8'h06, 32'h0,         32'h0000_BCDF},
            '{6'h0A, 8'h02, 32'h0,         32'h0000_4567},
            '{6'h0A, 8'h06, 32'h0,         32'hFFFF_BCDF},
            '{6'h04, 8'hFE, 32'hA1B2_C3D4, 32'hFFFF_BCDF},
            '{6'h08, 8'hFE, 32'h0,         32'hA1B2_C3D4},
            '{6'h3F, 8'h00, 32'hFFFF_FFFF, 32'hA1B2_C3D4}
        };
        foreach (vecs[i]) begin
            do_txn(vecs[i].op, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].exp);
        end
        check("wrap_fe", {24'h0, dut.ram[8'hFE]}, 32'hA1);
        check("wrap_ff", {24'h0, dut.ram[8'hFF]}, 32'hB2);
        check("wrap_00", {24'h0, dut.ram[8'h00]}, 32'hC3);
        check("wrap_01", {24'h0, dut.ram[8'h01]}, 32'hD4);
        check("st_07",   {24'h0, dut.ram[8'h07]}, 32'hDF);

        // MFA held through DONE with inputs changed: one write only, MFC stays up.
        opcode = 6'h04; addr = 8'h40; data_in = 32'h1122_3344; MFA = 1'b1;
        edges = 0; got = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk); #1; edges++;
            if (MFC) got = 1'b1;
            addr = 8'h44; data_in = 32'h5566_7788;
        end
        check("held_latency", 32'(edges), 32'(MFC_DELAY + 1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("held_mfc", {31'h0, MFC}, 32'h1);
        end
        MFA = 1'b0;
        @(posedge clk); #1;
        check("held_clear", {31'h0, MFC}, 32'h0);
        @(posedge clk); #1;
        check("held_idle", {31'h0, MFC}, 32'h0);
        model_apply(6'h04, 8'h40, 32'h1122_3344);
        check("held_ram40", {24'h0, dut.ram[8'h40]}, 32'h11);
        check("held_ram43", {24'h0, dut.ram[8'h43]}, 32'h44);
        check("held_ram44", {24'h0, dut.ram[8'h44]}, {24'h0, mem[8'h44]});

        // MFA dropped during BUSY: transaction still completes and MFC pulses.
        opcode = 6'h08; addr = 8'h40; MFA = 1'b1;
        @(posedge clk); #1;
        MFA = 1'b0;
        edges = 1; got = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk); #1; edges++;
            if (MFC) got = 1'b1;
        end
        check("drop_latency", 32'(edges), 32'(MFC_DELAY + 1));
        check("drop_dout", data_out, 32'h1122_3344);
        @(posedge clk); #1;
        check("drop_clear", {31'h0, MFC}, 32'h0);
        model_apply(6'h08, 8'h40, 32'h0);

        // Reset while BUSY aborts the pending store.
        do_txn(6'h05, 8'h10, 32'h0000_005A);
        opcode = 6'h05; addr = 8'h10; data_in = 32'h0000_0099; MFA = 1'b1;
        @(posedge clk); #1;
        MFA = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_busy_mfc", {31'h0, MFC}, 32'h0);
        check("rst_busy_dout", data_out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mdout = 32'h0;
        check("rst_busy_ram", {24'h0, dut.ram[8'h10]}, 32'h5A);
        @(posedge clk); #1;
        do_txn(6'h01, 8'h10, 32'h0);
        check("rst_after_ld", data_out, 32'h0000_005A);

        rops = '{6'h01, 6'h09, 6'h02, 6'h0A, 6'h08, 6'h05, 6'h06, 6'h04, 6'h3F, 6'h00};
        for (int i = 0; i < 200; i++) begin
            do_txn(rops[$urandom_range(0, 9)], 8'($urandom), $urandom);
            check("rand_dout", data_out, mdout);
        end
        for (int i = 0; i < 256; i++)
            check($sformatf("ram_%02h", i), {24'h0, dut.ram[i]}, {24'h0, mem[i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
